// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-fetch, D and memory-side signals around mem_port_arbiter.
// master: the arbiter's view. slave: the requesters and memory seen from outside.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction-fetch requester
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;

    // Data requester
    logic                d_read;
    logic                d_write;
    logic [DATA_W/8-1:0] d_byte_enable;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_resp;

    // Shared memory port
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_byte_enable;
    logic                mem_resp;
    logic [DATA_W-1:0]   mem_rdata;

    logic arb_busy;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_byte_enable, d_addr, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata,
        output arb_busy
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_byte_enable, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata,
        input  arb_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-fetch and D requesters.
// A winner is picked in IDLE, its command is latched, memory is driven only from the latch,
// the response is routed back, and a one-cycle RECOVER dead cycle follows every transaction.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break instead of D priority with an
// I-starvation counter. The port list is the same in both builds.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned BeW = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD,
        StRecover
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BeW-1:0]    be_q, be_d;
    logic              wr_q, wr_d;

    logic i_req, d_req;
    logic grant_i, grant_d;
    logic serve;

`ifdef ARB_ROUND_ROBIN_EN
    // High when D received the most recent grant; resets to "I last" so D wins the first tie.
    logic last_d_q, last_d_d;
`else
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    assign serve = (state_q == StServeI) || (state_q == StServeD);

    // Grant decision, only meaningful in IDLE
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == StIdle) begin
            if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_i = last_d_q;
`else
                grant_i = (starve_cnt_q == StarveMax);
`endif
                grant_d = ~grant_i;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember which requester got the latest grant
    always_comb begin
        last_d_d = last_d_q;
        if (grant_d) begin
            last_d_d = 1'b1;
        end else if (grant_i) begin
            last_d_d = 1'b0;
        end
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Count D grants that bypassed a waiting I; saturates, cleared by any I grant
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_i) begin
            starve_cnt_d = 4'd0;
        end else if (grant_d && i_req && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Next state and command latch
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StServeD;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    wr_d    = bus.d_write;
                    // Read+write together is a write; reads enable every byte
                    be_d    = bus.d_write ? bus.d_byte_enable : '1;
                end else if (grant_i) begin
                    state_d = StServeI;
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                    be_d    = '1;
                end
            end
            StServeI, StServeD: begin
                if (bus.mem_resp) begin
                    state_d = StRecover;
                end
            end
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State and latched command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    // Memory side is driven only from the latch and only while serving; zero otherwise
    always_comb begin
        bus.mem_read        = serve & ~wr_q;
        bus.mem_write       = serve & wr_q;
        bus.mem_address     = serve ? addr_q : '0;
        bus.mem_wdata       = serve ? wdata_q : '0;
        bus.mem_byte_enable = serve ? be_q : '0;
        bus.arb_busy        = serve;
    end

    // Response routing; mem_resp outside a serve state is dropped
    always_comb begin
        bus.i_resp  = (state_q == StServeI) & bus.mem_resp;
        bus.d_resp  = (state_q == StServeD) & bus.mem_resp;
        bus.i_rdata = bus.mem_rdata;
        bus.d_rdata = bus.mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_read        = 1'b0;
        bus.i_addr        = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_byte_enable = '0;
        bus.d_addr        = '0;
        bus.d_wdata       = '0;
        bus.mem_resp      = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Advance until memory sees a request, bounded
    task automatic wait_req();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("req_seen", 64'(seen), 64'd1);
    endtask

    // Called on the falling edge where the request is first visible; raise mem_resp in its lat-th cycle
    task automatic respond(input int lat, input logic [31:0] rdata);
        repeat (lat - 1) @(negedge clk);
        bus.mem_rdata = rdata;
        bus.mem_resp  = 1'b1;
        #1;
    endtask

    task automatic finish_resp();
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_eq("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check_eq("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check_eq("rst_busy", 64'(bus.arb_busy), 64'd0);
        check_eq("rst_addr", 64'(bus.mem_address), 64'd0);

        // 1: reset while serving a D write, then a stale response
        bus.d_write = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234; bus.d_byte_enable = 4'hF;
        @(negedge clk);
        check_eq("t1_write_up", 64'(bus.mem_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_async_write", 64'(bus.mem_write), 64'd0);
        check_eq("t1_async_busy", 64'(bus.arb_busy), 64'd0);
        check_eq("t1_async_addr", 64'(bus.mem_address), 64'd0);
        check_eq("t1_async_wdata", 64'(bus.mem_wdata), 64'd0);
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hAAAA5555;
        #1;
        check_eq("t1_stale_d_resp", 64'(bus.d_resp), 64'd0);
        check_eq("t1_stale_i_resp", 64'(bus.i_resp), 64'd0);
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check_eq("t1_idle_busy", 64'(bus.arb_busy), 64'd0);
        check_eq("t1_idle_write", 64'(bus.mem_write), 64'd0);

        // 2: I fetch, 3-cycle memory
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h60;
        @(negedge clk);
        check_eq("t2_mem_read", 64'(bus.mem_read), 64'd1);
        check_eq("t2_addr", 64'(bus.mem_address), 64'h60);
        check_eq("t2_busy", 64'(bus.arb_busy), 64'd1);
        respond(3, 32'h00000013);
        check_eq("t2_i_resp", 64'(bus.i_resp), 64'd1);
        check_eq("t2_i_rdata", 64'(bus.i_rdata), 64'h13);
        check_eq("t2_no_d_resp", 64'(bus.d_resp), 64'd0);
        bus.i_read = 1'b0;
        finish_resp();
        check_eq("t2_recover_read", 64'(bus.mem_read), 64'd0);
        check_eq("t2_resp_pulse", 64'(bus.i_resp), 64'd0);
        check_eq("t2_recover_busy", 64'(bus.arb_busy), 64'd0);

        // 3: D write with partial byte enables
        @(negedge clk);
        bus.d_write = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
        bus.d_byte_enable = 4'b0011;
        @(negedge clk);
        check_eq("t3_write", 64'(bus.mem_write), 64'd1);
        check_eq("t3_read", 64'(bus.mem_read), 64'd0);
        check_eq("t3_addr", 64'(bus.mem_address), 64'h100);
        check_eq("t3_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
        check_eq("t3_be", 64'(bus.mem_byte_enable), 64'h3);
        respond(2, 32'h0);
        check_eq("t3_d_resp", 64'(bus.d_resp), 64'd1);
        check_eq("t3_no_i_resp", 64'(bus.i_resp), 64'd0);
        bus.d_write = 1'b0;
        finish_resp();
        check_eq("t3_resp_pulse", 64'(bus.d_resp), 64'd0);
        check_eq("t3_recover_write", 64'(bus.mem_write), 64'd0);

        // 5: d_addr changes while serving; the latched address must hold
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_addr = 32'h200;
        @(negedge clk);
        check_eq("t5_read", 64'(bus.mem_read), 64'd1);
        check_eq("t5_be_all", 64'(bus.mem_byte_enable), 64'hF);
        bus.d_addr = 32'h300;
        @(negedge clk);
        check_eq("t5_addr_held", 64'(bus.mem_address), 64'h200);
        respond(2, 32'hCAFEF00D);
        check_eq("t5_addr_at_resp", 64'(bus.mem_address), 64'h200);
        check_eq("t5_d_resp", 64'(bus.d_resp), 64'd1);
        check_eq("t5_d_rdata", 64'(bus.d_rdata), 64'hCAFEF00D);
        bus.d_read = 1'b0;
        finish_resp();
        check_eq("t5_recover_addr", 64'(bus.mem_address), 64'd0);

        // 6: D arrives while I is being served; I finishes, D follows after RECOVER
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h80;
        @(negedge clk);
        check_eq("t6_i_read", 64'(bus.mem_read), 64'd1);
        check_eq("t6_i_addr", 64'(bus.mem_address), 64'h80);
        bus.d_read = 1'b1; bus.d_addr = 32'h240;
        respond(2, 32'h55);
        check_eq("t6_i_resp", 64'(bus.i_resp), 64'd1);
        check_eq("t6_no_d_resp", 64'(bus.d_resp), 64'd0);
        check_eq("t6_i_rdata", 64'(bus.i_rdata), 64'h55);
        bus.i_read = 1'b0;
        finish_resp();
        check_eq("t6_recover_read", 64'(bus.mem_read), 64'd0);
        @(negedge clk);
        check_eq("t6_idle_busy", 64'(bus.arb_busy), 64'd0);
        @(negedge clk);
        check_eq("t6_d_read", 64'(bus.mem_read), 64'd1);
        check_eq("t6_d_addr", 64'(bus.mem_address), 64'h240);
        respond(1, 32'h77);
        check_eq("t6_d_resp", 64'(bus.d_resp), 64'd1);
        check_eq("t6_d_rdata", 64'(bus.d_rdata), 64'h77);
        bus.d_read = 1'b0;
        finish_resp();

        // 4: both requesters held continuously; check grant order by address
        do_reset();
        bus.i_read = 1'b1; bus.i_addr = 32'h1000;
        bus.d_read = 1'b1; bus.d_addr = 32'h2000;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] exp_addr;
`ifdef ARB_ROUND_ROBIN_EN
            exp_addr = (k % 2 == 0) ? 32'h2000 : 32'h1000;
`else
            exp_addr = (k % 5 == 4) ? 32'h1000 : 32'h2000;
`endif
            wait_req();
            check_eq($sformatf("t4_grant%0d", k), 64'(bus.mem_address), 64'(exp_addr));
            respond(1, 32'(k));
            finish_resp();
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t4_idle_busy", 64'(bus.arb_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
